led_share_arbiter: RTL and testbench

- Round-robin arbiter sharing the board's LED bank between several requester blocks, e.g. the AND/OR gate demos, counters and pattern generators.
- Each requester presents a request and the LED pattern it wants to show.
- The arbiter grants exactly one owner at a time, enforces a minimum hold time before another requester can preempt, and drives the LEDs from a registered mux.
- It sits between the demo logic and the top-level o_LED pins.

---
 rtl/led_arb_pkg.sv | 47 ++++
 rtl/rr_priority_picker.sv | 32 +++
 rtl/led_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_led_share_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// -----------------------------------------------------------------------------
// led_arb_pkg
// Shared types and helpers for the LED-sharing arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWNED, HANDOFF)
//   rr_pick_t   : result of a rotating-priority search (valid flag + index)
//   f_RR_Pick   : rotating-priority search over up to MAX_REQ requesters,
//                 scanning upward from ptr+1 modulo num_req.
// -----------------------------------------------------------------------------
package led_arb_pkg;

    // Upper bound on requesters supported by the search helper.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        HANDOFF = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Requesters at or above num_req must be presented as zero by the caller.
    function automatic rr_pick_t f_RR_Pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        num_req
    );
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        // Offset 1 is checked first, so the last winner (offset num_req)
        // always ends up with the lowest priority.
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % num_req);
            if (i <= num_req && !pick.valid && req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotating-priority search.
//   req    : request vector, one bit per requester
//   ptr    : index of the previous winner (it gets lowest priority)
//   valid  : at least one request is present
//   idx    : index of the winner
//   onehot : one-hot form of the winner (all zero when valid is low)
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);
    import led_arb_pkg::*;

    rr_pick_t pick;

    always_comb begin
        pick = f_RR_Pick(MAX_REQ'(req), IDX_W'(ptr), NUM_REQ);
    end

    assign valid  = pick.valid;
    assign idx    = PTR_W'(pick.idx);
    assign onehot = pick.valid ? (NUM_REQ'(1) << pick.idx) : '0;

endmodule

// File: rtl/led_share_arbiter.sv
// -----------------------------------------------------------------------------
// led_share_arbiter
// Round-robin owner of the shared LED bank. One requester owns the LEDs at a
// time; after MIN_HOLD cycles of ownership another requester may preempt.
// Every ownership change passes through a single dead HANDOFF cycle.
//   i_Clk      : system clock
//   i_Reset    : asynchronous active-high reset (release it synchronously)
//   i_Req      : level-sensitive request, one bit per requester
//   i_LED_Data : LED patterns, requester n at [n*LED_WIDTH +: LED_WIDTH]
//   o_Grant    : registered one-hot grant, or all zero
//   o_LED      : registered LED pattern of the owner (one cycle behind)
//   o_Busy     : registered, high while a requester owns the LEDs
// -----------------------------------------------------------------------------
module led_share_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LED_WIDTH = 4,
    parameter int MIN_HOLD  = 25000000
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic [NUM_REQ-1:0]           i_Req,
    input  logic [NUM_REQ*LED_WIDTH-1:0] i_LED_Data,
    output logic [NUM_REQ-1:0]           o_Grant,
    output logic [LED_WIDTH-1:0]         o_LED,
    output logic                         o_Busy
);
    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(MIN_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [LED_WIDTH-1:0] led_q,   led_d;
    logic                 busy_q,  busy_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    // While OWNED, the pointer is also the owner's index.
    logic [PTR_W-1:0]     ptr_q,   ptr_d;

    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [LED_WIDTH-1:0] owner_led;
    logic                 owner_req;
    logic                 other_req;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (i_Req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        owner_led = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (ptr_q == PTR_W'(n)) begin
                owner_led = i_LED_Data[n*LED_WIDTH +: LED_WIDTH];
            end
        end
    end

    assign owner_req = i_Req[ptr_q];
    assign other_req = |(i_Req & ~grant_q);

    always_comb begin
        // NOTE: every _d signal takes its held value before the case, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE, HANDOFF: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    grant_d = pick_onehot;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    led_d   = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end
            end

            OWNED: begin
                // Voluntary release and preemption collapse into one transition.
                if (!owner_req || (cnt_q == HOLD_MAX && other_req)) begin
                    state_d = HANDOFF;
                    grant_d = '0;
                    led_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    led_d = owner_led;
                    if (cnt_q != HOLD_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                led_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments, so every register updates from the pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_Grant = grant_q;
    assign o_LED   = led_q;
    assign o_Busy  = busy_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_share_arbiter
// Directed bench for led_share_arbiter with NUM_REQ=4, LED_WIDTH=4, MIN_HOLD=4.
// Each vector holds the inputs that are applied before a rising edge and the
// outputs expected just after that edge.
// -----------------------------------------------------------------------------
module tb_led_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int LED_WIDTH = 4;
    localparam int MIN_HOLD  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] led_data;
    logic [3:0]  grant;
    logic [3:0]  led;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  grant;
        logic [3:0]  led;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    led_share_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .LED_WIDTH (LED_WIDTH),
        .MIN_HOLD  (MIN_HOLD)
    ) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Req      (req),
        .i_LED_Data (led_data),
        .o_Grant    (grant),
        .o_LED      (led),
        .o_Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input logic [3:0] el, input logic eb);
        check({tag, " grant"}, 16'(grant), 16'(eg));
        check({tag, " led"},   16'(led),   16'(el));
        check({tag, " busy"},  16'(busy),  16'(eb));
    endtask

    task automatic add(input logic [3:0] r, input logic [15:0] d,
                       input logic [3:0] eg, input logic [3:0] el, input logic eb);
        vec_t v;
        v.req = r; v.data = d; v.grant = eg; v.led = el; v.busy = eb;
        vq.push_back(v);
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic run_vectors(input string tag);
        foreach (vq[i]) begin
            req      = vq[i].req;
            led_data = vq[i].data;
            @(posedge clk); #1;
            check_outs($sformatf("%s v%0d", tag, i), vq[i].grant, vq[i].led, vq[i].busy);
        end
        vq.delete();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        led_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        led_data = '0;

        // Reset state, and staying idle with no requests.
        #2;
        check_outs("reset", 4'b0000, 4'h0, 1'b0);
        do_reset();
        @(posedge clk); #1;
        check_outs("idle", 4'b0000, 4'h0, 1'b0);

        // 1: single request, one-cycle grant, LED one cycle later.
        do_reset();
        add(4'b0100, 16'h0A00, 4'b0100, 4'h0, 1'b1);
        add(4'b0100, 16'h0A00, 4'b0100, 4'hA, 1'b1);
        add(4'b0100, 16'h0A00, 4'b0100, 4'hA, 1'b1);
        run_vectors("t1");

        // 2: all requesting: 0,1,2,3,0, five OWNED cycles each, one dead cycle between.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add(4'b1111, 16'h4321, 4'(1 << k), 4'h0,     1'b1);
            for (int c = 0; c < 4; c++) begin
                add(4'b1111, 16'h4321, 4'(1 << k), 4'(k + 1), 1'b1);
            end
            add(4'b1111, 16'h4321, 4'b0000, 4'h0, 1'b0);
        end
        add(4'b1111, 16'h4321, 4'b0001, 4'h0, 1'b1);
        add(4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1);
        run_vectors("t2");

        // 3: req1 arrives at counter=1; req0 holds through counter=4.
        do_reset();
        add(4'b0001, 16'h4321, 4'b0001, 4'h0, 1'b1);
        add(4'b0001, 16'h4321, 4'b0001, 4'h1, 1'b1);
        add(4'b0011, 16'h4321, 4'b0001, 4'h1, 1'b1);
        add(4'b0011, 16'h4321, 4'b0001, 4'h1, 1'b1);
        add(4'b0011, 16'h4321, 4'b0001, 4'h1, 1'b1);
        add(4'b0011, 16'h4321, 4'b0000, 4'h0, 1'b0);
        add(4'b0011, 16'h4321, 4'b0010, 4'h0, 1'b1);
        add(4'b0011, 16'h4321, 4'b0010, 4'h2, 1'b1);
        // Drop everything: HANDOFF then IDLE, pointer left at 1.
        add(4'b0000, 16'h4321, 4'b0000, 4'h0, 1'b0);
        add(4'b0000, 16'h4321, 4'b0000, 4'h0, 1'b0);
        // 4: req3 owns, releases after two cycles; pointer stays at 3.
        add(4'b1000, 16'h4321, 4'b1000, 4'h0, 1'b1);
        add(4'b1000, 16'h4321, 4'b1000, 4'h4, 1'b1);
        add(4'b0000, 16'h4321, 4'b0000, 4'h0, 1'b0);
        add(4'b0000, 16'h4321, 4'b0000, 4'h0, 1'b0);
        add(4'b1001, 16'h4321, 4'b0001, 4'h0, 1'b1);
        add(4'b1001, 16'h4321, 4'b0001, 4'h1, 1'b1);
        run_vectors("t3t4");

        // 5: req1 owns with 5 while req2's data toggles; counter saturates and
        // the owner keeps the LEDs until another requester shows up.
        do_reset();
        add(4'b0010, 16'h0A50, 4'b0010, 4'h0, 1'b1);
        add(4'b0010, 16'h0350, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0A50, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0350, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0A50, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0350, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0A50, 4'b0010, 4'h5, 1'b1);
        add(4'b0010, 16'h0350, 4'b0010, 4'h5, 1'b1);
        add(4'b0110, 16'h0A50, 4'b0000, 4'h0, 1'b0);
        add(4'b0110, 16'h0A50, 4'b0100, 4'h0, 1'b1);
        add(4'b0110, 16'h0A50, 4'b0100, 4'hA, 1'b1);
        // Single requester regains after one HANDOFF cycle.
        add(4'b0000, 16'h0A50, 4'b0000, 4'h0, 1'b0);
        add(4'b0100, 16'h0A50, 4'b0100, 4'h0, 1'b1);
        // Re-raised during HANDOFF it has lowest priority: req0 wins.
        add(4'b0000, 16'h0A50, 4'b0000, 4'h0, 1'b0);
        add(4'b0101, 16'h0A50, 4'b0001, 4'h0, 1'b1);
        run_vectors("t5");

        // 6: asynchronous reset in the middle of a cycle while req0 owns.
        do_reset();
        add(4'b0001, 16'h4321, 4'b0001, 4'h0, 1'b1);
        add(4'b0001, 16'h4321, 4'b0001, 4'h1, 1'b1);
        run_vectors("t6");
        #3;
        rst = 1'b1;
        #1;
        check_outs("t6 async", 4'b0000, 4'h0, 1'b0);
        req      = 4'b0011;
        led_data = 16'h4321;
        @(posedge clk); #1;
        check_outs("t6 held", 4'b0000, 4'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_outs("t6 regrant", 4'b0001, 4'h0, 1'b1);
        @(posedge clk); #1;
        check_outs("t6 led", 4'b0001, 4'h1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
